maze_renderer: RTL and testbench

- Parametrised, pipelined successor of the maze pixel generator.
- Maps each raster coordinate from the VGA timing generator to a 12-bit colour, covering four modes: map, welcome, win and paused.
- Compared with the earlier generator, it adds:
  - correct index/pixel alignment through a fixed 3-cycle pipeline;
  - optional cell grid lines;
  - a frame-counted blinking cursor in paused mode;
  - data-enable passthrough.

---
 rtl/maze_pkg.sv | 28 ++
 rtl/maze_renderer_if.sv | 40 ++++
 rtl/maze_renderer_cursor_blink.sv | 61 ++++++
 rtl/maze_renderer.sv | 185 ++++++++++++++++++
 tb/tb_maze_renderer.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : maze_pkg                                                   |
// | Brief   : Shared colour constants and mode encodings for the maze    |
// |           renderer and its helper blocks.                            |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package maze_pkg;

  // RGB444 palette
  localparam logic [11:0] RED       = 12'hF00;
  localparam logic [11:0] BLACK     = 12'h000;
  localparam logic [11:0] WHITE     = 12'hFFF;
  localparam logic [11:0] GRAY      = 12'hDDD;
  localparam logic [11:0] GRID_GRAY = 12'h888;
  localparam logic [11:0] YELLOW    = 12'hFF0;
  localparam logic [11:0] GREEN     = 12'h0F0;

  // Display modes driven by the game controller
  typedef enum logic [1:0] {
    MODE_MAP     = 2'b00,
    MODE_WELCOME = 2'b01,
    MODE_WIN     = 2'b10,
    MODE_PAUSE   = 2'b11
  } mode_e;

endpackage : maze_pkg
`default_nettype wire

// File: rtl/maze_renderer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : maze_renderer_if                                           |
// | Brief   : Raster-in / pixel-out bundle of the maze renderer. The     |
// |           master side supplies timing, mode and map state; the slave |
// |           side returns the coloured pixel stream.                    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface maze_renderer_if #(
  parameter int IDX_W = 5,
  parameter int MAX_N = 19
) ();

  logic                   frame_start;
  logic                   de;
  logic [1:0]             mode;
  logic [9:0]             x;
  logic [8:0]             y;
  logic [IDX_W-1:0]       num;
  logic [MAX_N*MAX_N-1:0] map;
  logic [IDX_W-1:0]       cur_x;
  logic [IDX_W-1:0]       cur_y;
  logic [11:0]            pix_data;
  logic                   pix_de;
  logic [IDX_W-1:0]       pix_x_index;
  logic [IDX_W-1:0]       pix_y_index;
  logic                   in_map;

  modport master (
    output frame_start, de, mode, x, y, num, map, cur_x, cur_y,
    input  pix_data, pix_de, pix_x_index, pix_y_index, in_map
  );

  modport slave (
    input  frame_start, de, mode, x, y, num, map, cur_x, cur_y,
    output pix_data, pix_de, pix_x_index, pix_y_index, in_map
  );

endinterface : maze_renderer_if
`default_nettype wire

// File: rtl/maze_renderer_cursor_blink.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cursor_blink                                               |
// | Brief   : Frame counter that toggles the paused-mode cursor every    |
// |           BLINK_FRAMES frames; entering pause restarts it visible.   |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module cursor_blink #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start_i,
  input  logic [1:0] mode_i,
  output logic       blink_on_o
);
  import maze_pkg::*;

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             on_q, on_d;
  logic [1:0]       mode_q;
  logic             w_enter_pause;

  // Next count/phase; a fresh entry into pause wins over a frame tick
  always_comb begin
    cnt_d         = cnt_q;
    on_d          = on_q;
    w_enter_pause = (mode_i == MODE_PAUSE) && (mode_q != MODE_PAUSE);
    if (w_enter_pause) begin
      cnt_d = '0;
      on_d  = 1'b1;
    end else if (frame_start_i) begin
      if (cnt_q == C_LAST) begin
        cnt_d = '0;
        on_d  = ~on_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter, phase and previous-mode registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      on_q   <= 1'b1;
      mode_q <= MODE_MAP;
    end else begin
      cnt_q  <= cnt_d;
      on_q   <= on_d;
      mode_q <= mode_i;
    end
  end

  assign blink_on_o = on_q;

endmodule : cursor_blink
`default_nettype wire

// File: rtl/maze_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : maze_renderer                                              |
// | Brief   : 3-stage pipelined maze pixel colour generator. S1 offsets  |
// |           the raster position into map space, S2 splits it into      |
// |           cell index and in-cell offset, S3 picks the colour.        |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module maze_renderer #(
  parameter int MAP_CENTER_X = 240,
  parameter int MAP_CENTER_Y = 240,
  parameter int BLOCK_W      = 24,
  parameter int MAX_N        = 19,
  parameter int IDX_W        = 5,
  parameter int BLINK_FRAMES = 30,
  parameter int GRID_EN      = 1
) (
  input  logic           clk,
  input  logic           rst,
  maze_renderer_if.slave bus
);
  import maze_pkg::*;

  localparam int MAP_BITS = MAX_N * MAX_N;
  localparam int OFF_W    = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
  localparam logic [11:0]      C_BLOCK = 12'(BLOCK_W);
  localparam logic [11:0]      C_CX    = 12'(MAP_CENTER_X);
  localparam logic [11:0]      C_CY    = 12'(MAP_CENTER_Y);
  localparam logic [IDX_W-1:0] C_MAX_N = IDX_W'(MAX_N);

  // The largest map must fit left/above of the centre or bx/by underflow
  if ((BLOCK_W * MAX_N / 2 > MAP_CENTER_X) || (BLOCK_W * MAX_N / 2 > MAP_CENTER_Y)) begin : g_bad_geometry
    $error("maze_renderer: map does not fit around its centre");
  end

  // ---------------- S1 ----------------
  logic [IDX_W-1:0] w_neff;
  logic [11:0]      w_span, w_bx, w_by, w_px, w_py;
  logic             w_inside;

  logic                de_s1_q, inside_s1_q;
  logic [1:0]          mode_s1_q;
  logic [11:0]         rx_s1_q, ry_s1_q;
  logic [MAP_BITS-1:0] map_s1_q;
  logic [IDX_W-1:0]    neff_s1_q, curx_s1_q, cury_s1_q;

  // ---------------- S2 ----------------
  logic [IDX_W-1:0]    col_d, row_d;
  logic [OFF_W-1:0]    ox_d, oy_d;

  logic                de_s2_q, inside_s2_q;
  logic [1:0]          mode_s2_q;
  logic [IDX_W-1:0]    col_s2_q, row_s2_q;
  logic [OFF_W-1:0]    ox_s2_q, oy_s2_q;
  logic [MAP_BITS-1:0] map_s2_q;
  logic [IDX_W-1:0]    neff_s2_q, curx_s2_q, cury_s2_q;

  // ---------------- S3 ----------------
  logic [11:0]      w_wall_idx;
  logic             w_wall, w_cur_hit, w_start, w_end;
  logic             w_blink_on;
  logic [11:0]      color_d;

  logic [11:0]      pix_data_q;
  logic             pix_de_q, in_map_q;
  logic [IDX_W-1:0] pix_x_q, pix_y_q;

  cursor_blink #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink (
    .clk           (clk),
    .rst           (rst),
    .frame_start_i (bus.frame_start),
    .mode_i        (bus.mode),
    .blink_on_o    (w_blink_on)
  );

  // Map placement for the current size and the inside test for this pixel
  always_comb begin
    w_neff   = (bus.num > C_MAX_N) ? C_MAX_N : bus.num;
    w_span   = C_BLOCK * 12'(w_neff);
    w_bx     = C_CX - (w_span >> 1);
    w_by     = C_CY - (w_span >> 1);
    w_px     = 12'(bus.x);
    w_py     = 12'(bus.y);
    w_inside = bus.de && (w_px >= w_bx) && (w_px < w_bx + w_span)
                      && (w_py >= w_by) && (w_py < w_by + w_span);
  end

  // Stage valids and inside flags, flushed by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      de_s1_q     <= 1'b0;
      inside_s1_q <= 1'b0;
      de_s2_q     <= 1'b0;
      inside_s2_q <= 1'b0;
    end else begin
      de_s1_q     <= bus.de;
      inside_s1_q <= w_inside;
      de_s2_q     <= de_s1_q;
      inside_s2_q <= inside_s1_q;
    end
  end

  // Constant-divisor split of the map-relative position into cell and offset
  always_comb begin
    col_d = IDX_W'(rx_s1_q / C_BLOCK);
    row_d = IDX_W'(ry_s1_q / C_BLOCK);
    ox_d  = OFF_W'(rx_s1_q % C_BLOCK);
    oy_d  = OFF_W'(ry_s1_q % C_BLOCK);
  end

  // Pipeline payload; map/size/cursor travel with the pixel they belong to
  always_ff @(posedge clk) begin
    mode_s1_q <= bus.mode;
    rx_s1_q   <= w_px - w_bx;
    ry_s1_q   <= w_py - w_by;
    map_s1_q  <= bus.map;
    neff_s1_q <= w_neff;
    curx_s1_q <= bus.cur_x;
    cury_s1_q <= bus.cur_y;

    mode_s2_q <= mode_s1_q;
    col_s2_q  <= col_d;
    row_s2_q  <= row_d;
    ox_s2_q   <= ox_d;
    oy_s2_q   <= oy_d;
    map_s2_q  <= map_s1_q;
    neff_s2_q <= neff_s1_q;
    curx_s2_q <= curx_s1_q;
    cury_s2_q <= cury_s1_q;
  end

  // Colour priority: blanking, full-screen modes, outside, cursor, markers, wall, grid
  always_comb begin
    w_wall_idx = 12'(row_s2_q) * 12'(neff_s2_q) + 12'(col_s2_q);
    w_wall     = inside_s2_q && 1'(map_s2_q >> w_wall_idx);
    w_cur_hit  = (col_s2_q == curx_s2_q) && (row_s2_q == cury_s2_q)
                 && (curx_s2_q < neff_s2_q) && (cury_s2_q < neff_s2_q)
                 && ((mode_s2_q == MODE_MAP) || w_blink_on);
    w_start    = (col_s2_q == IDX_W'(1)) && (row_s2_q == IDX_W'(1));
    w_end      = (neff_s2_q >= IDX_W'(3))
                 && (col_s2_q == neff_s2_q - IDX_W'(2))
                 && (row_s2_q == neff_s2_q - IDX_W'(2));
    color_d    = GRAY;
    if (!de_s2_q)                                       color_d = BLACK;
    else if (mode_s2_q == MODE_WELCOME)                 color_d = YELLOW;
    else if (mode_s2_q == MODE_WIN)                     color_d = RED;
    else if (!inside_s2_q)                              color_d = WHITE;
    else if (w_cur_hit)                                 color_d = RED;
    else if (w_start)                                   color_d = GREEN;
    else if (w_end)                                     color_d = YELLOW;
    else if (w_wall)                                    color_d = BLACK;
    else if ((GRID_EN != 0) && ((ox_s2_q == '0) || (oy_s2_q == '0)))
                                                        color_d = GRID_GRAY;
    else                                                color_d = GRAY;
  end

  // Output register; cell indices only follow pixels inside the map
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_data_q <= '0;
      pix_de_q   <= 1'b0;
      in_map_q   <= 1'b0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
    end else begin
      pix_data_q <= color_d;
      pix_de_q   <= de_s2_q;
      in_map_q   <= inside_s2_q;
      if (inside_s2_q) begin
        pix_x_q <= col_s2_q;
        pix_y_q <= row_s2_q;
      end
    end
  end

  assign bus.pix_data    = pix_data_q;
  assign bus.pix_de      = pix_de_q;
  assign bus.in_map      = in_map_q;
  assign bus.pix_x_index = pix_x_q;
  assign bus.pix_y_index = pix_y_q;

endmodule : maze_renderer
`default_nettype wire

// File: tb/tb_maze_renderer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_maze_renderer                                           |
// | Brief   : Directed vector bench for maze_renderer (num=19 default,   |
// |           BLINK_FRAMES=2 for the cursor blink sequences).            |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_maze_renderer;

  localparam int IDX_W = 5;
  localparam int MAX_N = 19;
  localparam int NV    = 21;

  typedef struct {
    logic [1:0]  mode;
    logic        de;
    int          x;
    int          y;
    int          num;
    int          cx;
    int          cy;
    logic        wen;
    int          wbit;
    logic [11:0] exp_data;
    logic        exp_in;
    logic        chk_idx;
    int          xi;
    int          yi;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs [0:NV-1];

  maze_renderer_if #(.IDX_W(IDX_W), .MAX_N(MAX_N)) bus ();

  maze_renderer #(
    .MAP_CENTER_X (240),
    .MAP_CENTER_Y (240),
    .BLOCK_W      (24),
    .MAX_N        (MAX_N),
    .IDX_W        (IDX_W),
    .BLINK_FRAMES (2),
    .GRID_EN      (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    logic [MAX_N*MAX_N-1:0] m;
    m = '0;
    if (v.wen) m[v.wbit] = 1'b1;
    bus.mode  = v.mode;
    bus.de    = v.de;
    bus.x     = 10'(v.x);
    bus.y     = 9'(v.y);
    bus.num   = IDX_W'(v.num);
    bus.cur_x = IDX_W'(v.cx);
    bus.cur_y = IDX_W'(v.cy);
    bus.map   = m;
  endtask

  task automatic check_vec(input int i);
    vec_t v;
    v = vecs[i];
    chk($sformatf("vec%0d data", i), bus.pix_data, v.exp_data);
    chk($sformatf("vec%0d de", i), 12'(bus.pix_de), 12'(v.de));
    chk($sformatf("vec%0d in_map", i), 12'(bus.in_map), 12'(v.exp_in));
    if (v.chk_idx) begin
      chk($sformatf("vec%0d xidx", i), 12'(bus.pix_x_index), 12'(v.xi));
      chk($sformatf("vec%0d yidx", i), 12'(bus.pix_y_index), 12'(v.yi));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fs_pulse();
    bus.frame_start = 1'b1;
    tick(1);
    bus.frame_start = 1'b0;
  endtask

  initial begin
    //           mode  de  x    y    num cx cy wen wbit exp      in  chk xi  yi
    vecs[0]  = '{2'd0, 1, 11,  100, 19, 0, 0, 0, 0,  12'hFFF, 0, 0, 0,  0};
    vecs[1]  = '{2'd0, 1, 37,  37,  19, 0, 0, 0, 0,  12'h0F0, 1, 1, 1,  1};
    vecs[2]  = '{2'd0, 1, 420, 420, 19, 0, 0, 0, 0,  12'hFF0, 1, 1, 17, 17};
    vecs[3]  = '{2'd0, 1, 61,  40,  19, 0, 0, 0, 0,  12'hDDD, 1, 1, 2,  1};
    vecs[4]  = '{2'd0, 1, 60,  40,  19, 0, 0, 0, 0,  12'h888, 1, 1, 2,  1};
    vecs[5]  = '{2'd0, 1, 12,  12,  19, 5, 5, 0, 0,  12'h888, 1, 1, 0,  0};
    vecs[6]  = '{2'd0, 1, 467, 100, 19, 0, 0, 0, 0,  12'hDDD, 1, 1, 18, 3};
    vecs[7]  = '{2'd0, 1, 468, 100, 19, 0, 0, 0, 0,  12'hFFF, 0, 0, 0,  0};
    vecs[8]  = '{2'd0, 1, 84,  132, 19, 0, 0, 1, 98, 12'h000, 1, 1, 3,  5};
    vecs[9]  = '{2'd0, 1, 84,  132, 19, 3, 5, 1, 98, 12'hF00, 1, 1, 3,  5};
    vecs[10] = '{2'd0, 0, 61,  40,  19, 0, 0, 0, 0,  12'h000, 0, 0, 0,  0};
    vecs[11] = '{2'd1, 1, 61,  40,  19, 0, 0, 0, 0,  12'hFF0, 1, 0, 0,  0};
    vecs[12] = '{2'd2, 1, 11,  100, 19, 0, 0, 0, 0,  12'hF00, 0, 0, 0,  0};
    vecs[13] = '{2'd3, 1, 84,  132, 19, 3, 5, 1, 98, 12'hF00, 1, 1, 3,  5};
    vecs[14] = '{2'd0, 1, 233, 233, 3,  3, 0, 0, 0,  12'h0F0, 1, 1, 1,  1};
    vecs[15] = '{2'd0, 1, 260, 210, 3,  3, 0, 0, 0,  12'hDDD, 1, 1, 2,  0};
    vecs[16] = '{2'd0, 1, 203, 210, 3,  3, 0, 0, 0,  12'hFFF, 0, 0, 0,  0};
    vecs[17] = '{2'd0, 1, 275, 275, 3,  3, 0, 0, 0,  12'hDDD, 1, 1, 2,  2};
    vecs[18] = '{2'd0, 1, 275, 275, 3,  2, 2, 0, 0,  12'hF00, 1, 1, 2,  2};
    vecs[19] = '{2'd0, 1, 420, 420, 25, 0, 0, 0, 0,  12'hFF0, 1, 1, 17, 17};
    vecs[20] = '{2'd0, 1, 240, 240, 0,  0, 0, 0, 0,  12'hFFF, 0, 0, 0,  0};

    // Reset state
    rst = 1'b1;
    bus.frame_start = 1'b0;
    apply(vecs[0]);
    bus.de = 1'b0;
    tick(3);
    chk("reset data", bus.pix_data, 12'h000);
    chk("reset de", 12'(bus.pix_de), 12'h0);
    chk("reset in_map", 12'(bus.in_map), 12'h0);
    chk("reset xidx", 12'(bus.pix_x_index), 12'h0);
    chk("reset yidx", 12'(bus.pix_y_index), 12'h0);
    rst = 1'b0;
    tick(2);

    // Back-to-back vectors: vector c-3 must be on the outputs when c is applied
    for (int c = 0; c < NV + 3; c++) begin
      if (c >= 3) check_vec(c - 3);
      if (c < NV) apply(vecs[c]);
      else        bus.de = 1'b0;
      tick(1);
    end

    // Paused cursor over a wall: RED,RED,BLACK,BLACK,RED,RED,BLACK
    apply(vecs[9]);
    tick(3);
    bus.mode = 2'd3;
    tick(5);
    chk("blink f0", bus.pix_data, 12'hF00);
    fs_pulse(); tick(5); chk("blink f1", bus.pix_data, 12'hF00);
    fs_pulse(); tick(5); chk("blink f2", bus.pix_data, 12'h000);
    fs_pulse(); tick(5); chk("blink f3", bus.pix_data, 12'h000);
    fs_pulse(); tick(5); chk("blink f4", bus.pix_data, 12'hF00);
    fs_pulse(); tick(5); chk("blink f5", bus.pix_data, 12'hF00);
    fs_pulse(); tick(5); chk("blink f6", bus.pix_data, 12'h000);

    // Re-entry into pause together with a frame tick restarts visible
    bus.mode = 2'd0;
    tick(1);
    bus.mode = 2'd3;
    fs_pulse(); tick(5); chk("reentry f0", bus.pix_data, 12'hF00);
    fs_pulse(); tick(5); chk("reentry f1", bus.pix_data, 12'hF00);
    fs_pulse(); tick(5); chk("reentry f2", bus.pix_data, 12'h000);

    // One-cycle reset mid-stream, then pix_de returns after 3 cycles
    apply(vecs[3]);
    tick(4);
    chk("pre-rst data", bus.pix_data, 12'hDDD);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid-rst data", bus.pix_data, 12'h000);
    chk("mid-rst de", 12'(bus.pix_de), 12'h0);
    chk("mid-rst in_map", 12'(bus.in_map), 12'h0);
    chk("mid-rst xidx", 12'(bus.pix_x_index), 12'h0);
    tick(1);
    chk("post-rst de+1", 12'(bus.pix_de), 12'h0);
    tick(1);
    chk("post-rst de+2", 12'(bus.pix_de), 12'h0);
    tick(1);
    chk("post-rst de+3", 12'(bus.pix_de), 12'h1);
    chk("post-rst data", bus.pix_data, 12'hDDD);
    chk("post-rst xidx", 12'(bus.pix_x_index), 12'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_maze_renderer
`default_nettype wire
